// File: rtl/prescaled_up_counter.sv
// prescaled_up_counter: modulo max_val+1 up counter with prescaler, load, one-shot halt, tc pulse and sticky ovf
module prescaled_up_counter #(
  parameter int WIDTH = 4,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]     max_val,
  input  logic                 one_shot,
  input  logic                 clr_ovf,
  output logic [WIDTH-1:0]     count,
  output logic                 tc,
  output logic                 ovf,
  output logic                 running
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic [PRE_WIDTH-1:0] pre_cnt;
  logic tick, adv, at_max, hit, tc_nxt;
  always_comb begin
    tick = en && pre_cnt >= prescale;
    adv = tick && state == RUN;
    at_max = count >= max_val;
    hit = WIDTH'(count + 1'b1) == max_val;
    tc_nxt = !load && adv && (at_max ? !one_shot : one_shot && hit);
  end
  assign running = state == RUN && en;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      pre_cnt <= '0;
      count <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= tc_nxt;
      ovf <= tc_nxt | (ovf & ~clr_ovf);
      if (load) begin
        count <= load_val;
        pre_cnt <= '0;
        state <= RUN;
      end else begin
        if (en) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (adv) count <= at_max ? '0 : count + 1'b1;
        if (adv && !at_max && one_shot && hit) state <= HALT;
      end
    end
endmodule

// File: tb/tb_prescaled_up_counter.sv
// tb_prescaled_up_counter: directed vectors, expected outputs queued per cycle and checked by a monitor
module tb_prescaled_up_counter;
  logic clk = 0, rst = 0, en = 0, load = 0, one_shot = 0, clr_ovf = 0;
  logic [3:0] load_val = 0, prescale = 0, max_val = 15;
  logic [3:0] count;
  logic tc, ovf, running;
  typedef struct {int c; int t; int o; int r;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  prescaled_up_counter #(.WIDTH(4), .PRE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .prescale(prescale), .max_val(max_val), .one_shot(one_shot),
    .clr_ovf(clr_ovf), .count(count), .tc(tc), .ovf(ovf), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("count", int'(count), e.c);
      chk("tc", int'(tc), e.t);
      chk("ovf", int'(ovf), e.o);
      chk("running", int'(running), e.r);
    end

  task automatic step(input int c, input int t, input int o, input int r);
    q.push_back('{c, t, o, r});
    @(negedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_running", int'(running), 0);
    rst = 1; en = 1; prescale = 0; max_val = 15; one_shot = 0;
    for (int i = 1; i <= 15; i++) step(i, 0, 0, 1);
    step(0, 1, 1, 1);
    step(1, 0, 1, 1);
    max_val = 5; prescale = 2; load = 1; load_val = 0;
    step(0, 0, 1, 1);
    load = 0;
    for (int k = 1; k <= 10; k++) step((k / 3) % 6, 0, 1, 1);
    en = 0;
    repeat (4) step(3, 0, 1, 0);
    en = 1;
    for (int k = 11; k <= 19; k++) step((k / 3) % 6, (k == 18) ? 1 : 0, 1, 1);
    one_shot = 1; max_val = 9; prescale = 0; load = 1; load_val = 0;
    step(0, 0, 1, 1);
    load = 0;
    for (int i = 1; i <= 8; i++) step(i, 0, 1, 1);
    step(9, 1, 1, 0);
    step(9, 0, 1, 0);
    step(9, 0, 1, 0);
    load = 1; load_val = 3;
    step(3, 0, 1, 1);
    load = 0;
    step(4, 0, 1, 1);
    en = 0; clr_ovf = 1;
    step(4, 0, 0, 0);
    en = 1; clr_ovf = 0; one_shot = 0; max_val = 7; load = 1; load_val = 12;
    step(12, 0, 0, 1);
    load = 0; clr_ovf = 1;
    step(0, 1, 1, 1);
    clr_ovf = 0;
    step(1, 0, 1, 1);
    load = 1; load_val = 5;
    step(5, 0, 1, 1);
    load = 0;
    step(6, 0, 1, 1);
    step(7, 0, 1, 1);
    step(0, 1, 1, 1);
    step(1, 0, 1, 1);
    max_val = 0; load = 1; load_val = 0;
    step(0, 0, 1, 1);
    load = 0;
    repeat (3) step(0, 1, 1, 1);
    max_val = 7; prescale = 2; load = 1; load_val = 6;
    step(6, 0, 1, 1);
    load = 0;
    step(6, 0, 1, 1);
    rst = 0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_tc", int'(tc), 0);
    chk("async_ovf", int'(ovf), 0);
    @(negedge clk);
    #2;
    rst = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
